// File: rtl/day_11_load_scheduler.sv
// Preset scheduler: buffers up to 4 reload values and strobes one into a loadable counter on terminal count.
// Latency: terminal match sampled at edge N -> load_o/load_val_o valid between edges N and N+1; miss_o likewise.
// Backpressure: val_ready_o drops when 4 presets are buffered; offers made while full are not taken.
module day_11_load_scheduler (
  input  logic       clk,
  input  logic       reset,
  input  logic       val_valid_i,
  input  logic [3:0] val_i,
  output logic       val_ready_o,
  input  logic [3:0] count_i,
  input  logic [3:0] term_i,
  output logic       load_o,
  output logic [3:0] load_val_o,
  output logic [2:0] level_o,
  output logic       miss_o,
  output logic [3:0] miss_cnt_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    LOAD  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] mem_q [4];
  logic [3:0] mem_d [4];
  logic [1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0] level_q, level_d;
  logic [3:0] load_val_q, load_val_d;
  logic       miss_q, miss_d;
  logic [3:0] miss_cnt_q, miss_cnt_d;

  logic       match;
  logic       push;
  logic       pop;

  // Ready depends only on the registered level, so a pop on the same edge never frees a slot early.
  assign val_ready_o = (level_q < 3'd4);
  assign match       = (count_i == term_i);
  assign push        = val_valid_i && val_ready_o;
  // Only ARMED pops; a match during LOAD is deliberately ignored.
  assign pop         = (state_q == ARMED) && match;

  assign load_o      = (state_q == LOAD);
  assign load_val_o  = load_val_q;
  assign level_o     = level_q;
  assign miss_o      = miss_q;
  assign miss_cnt_o  = miss_cnt_q;

  // FIFO storage, wrapping 2-bit pointers and occupancy; push and pop on one edge leave level unchanged.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      mem_d[wr_ptr_q] = val_i;
      wr_ptr_d        = wr_ptr_q + 2'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end
    if (push && !pop) begin
      level_d = level_q + 3'd1;
    end else if (pop && !push) begin
      level_d = level_q - 3'd1;
    end
  end

  // Scheduler FSM next state plus the registered load value and miss bookkeeping.
  always_comb begin
    state_d    = state_q;
    load_val_d = load_val_q;
    miss_d     = 1'b0;
    miss_cnt_d = miss_cnt_q;
    case (state_q)
      IDLE: begin
        // FIFO was empty when sampled, so a match here is a miss even if a push lands this edge.
        if (match) begin
          miss_d = 1'b1;
          if (miss_cnt_q != 4'hF) begin
            miss_cnt_d = miss_cnt_q + 4'd1;
          end
        end
        if (level_d != 3'd0) begin
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (match) begin
          load_val_d = mem_q[rd_ptr_q];
          state_d    = LOAD;
        end
      end
      LOAD: begin
        // Use the updated level so a push during the strobe cycle keeps us armed.
        state_d = (level_d != 3'd0) ? ARMED : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset clears everything asynchronously, including buffered presets.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      mem_q      <= '{default: 4'h0};
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      level_q    <= 3'd0;
      load_val_q <= 4'h0;
      miss_q     <= 1'b0;
      miss_cnt_q <= 4'h0;
    end else begin
      state_q    <= state_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      load_val_q <= load_val_d;
      miss_q     <= miss_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

endmodule
